// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage: bus widths,
// fetch FSM encoding and decoding helpers for the byte-issue states.
package inst_fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IF_ISSUE0 = 3'd0,
    IF_ISSUE1 = 3'd1,
    IF_ISSUE2 = 3'd2,
    IF_ISSUE3 = 3'd3,
    IF_DRAIN  = 3'd4,
    IF_VALID  = 3'd5
  } if_state_e;

  function automatic logic is_issue(input if_state_e s);
    return (s == IF_ISSUE0) || (s == IF_ISSUE1) ||
           (s == IF_ISSUE2) || (s == IF_ISSUE3);
  endfunction

  // ISSUEk is encoded as k, so the byte lane is simply the low two bits.
  function automatic logic [1:0] issue_lane(input if_state_e s);
    logic [2:0] v;
    v = s;
    return v[1:0];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Byte-wide memory read port shared between the fetch stage and the
// memory arbiter.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  // A request is accepted in any cycle where mem_rd_o & mem_grant_i are both
  // high; the addressed byte is presented on mem_din_i during the next cycle.
  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_rd_o;
  logic [BYTE_W-1:0] mem_din_i;
  logic              mem_grant_i;

  modport master (
    output mem_a_o,
    output mem_rd_o,
    input  mem_din_i,
    input  mem_grant_i
  );

  modport slave (
    input  mem_a_o,
    input  mem_rd_o,
    output mem_din_i,
    output mem_grant_i
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: assembles each 32-bit little-endian instruction
// from four byte reads and holds it for the IF/ID register until consumed.
module inst_fetch
  import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    inst_fetch_if.master      mem,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output if_state_e         dbg_state_o
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              pend_q, pend_d;
    logic [1:0]        lane_q, lane_d;
    logic              issuing;
    logic              accept;

    assign issuing      = is_issue(state_q);
    assign mem.mem_rd_o = issuing & ~rst;
    assign mem.mem_a_o  = issuing ? pc_q + {{(ADDR_W-2){1'b0}}, issue_lane(state_q)}
                                  : pc_q;
    // A redirect in the same cycle abandons the request, so it never counts.
    assign accept       = mem.mem_rd_o & mem.mem_grant_i & ~branch_flag_i;

    always_comb begin
        inst_d = inst_q;
        if (pend_q && !branch_flag_i) begin
            inst_d[{lane_q, 3'b000} +: BYTE_W] = mem.mem_din_i;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = 1'b0;
        lane_d  = lane_q;
        if (branch_flag_i) begin
            state_d = IF_ISSUE0;
            pc_d    = branch_target_i & ~32'h0000_0003;
        end else begin
            if (accept) begin
                pend_d = 1'b1;
                lane_d = issue_lane(state_q);
            end
            case (state_q)
                IF_ISSUE0: if (accept) state_d = IF_ISSUE1;
                IF_ISSUE1: if (accept) state_d = IF_ISSUE2;
                IF_ISSUE2: if (accept) state_d = IF_ISSUE3;
                IF_ISSUE3: if (accept) state_d = IF_DRAIN;
                IF_DRAIN:  state_d = IF_VALID;
                IF_VALID: begin
                    if (!stall_i) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = IF_ISSUE0;
                    end
                end
                default:   state_d = IF_ISSUE0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_ISSUE0;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pend_q  <= 1'b0;
            lane_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
        end
    end

    assign if_pc_o     = pc_q;
    assign if_inst_o   = inst_q;
    assign if_valid_o  = (state_q == IF_VALID);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed latency/stall/branch/wrap/reset cases, then
// randomized grant/stall/branch traffic checked by a PC-stream scoreboard.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    if_state_e   dbg_state;

    inst_fetch_if mem_if ();

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_flag_i   (branch),
        .branch_target_i (target),
        .mem             (mem_if.master),
        .if_pc_o         (if_pc),
        .if_inst_o       (if_inst),
        .if_valid_o      (if_valid),
        .dbg_state_o     (dbg_state)
    );

    // Scoreboard: each entry is {pc, instruction} of the fetch expected next.
    logic [63:0] exp_q[$];
    int n_tests;
    int n_fail;
    int n_handoff;
    int byte_cnt;
    int idle_cnt;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[31:24] ^ a[15:8] ^ 8'h6C;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
                mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    function automatic logic [63:0] entry(input logic [31:0] pc);
        return {pc, exp_word(pc)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        mem_if.mem_grant_i = 1'b1;
        repeat (2) tick();
        exp_q.delete();
        exp_q.push_back(entry(RESET_PC));
        rst = 1'b0;
        #1;
    endtask

    task automatic set_branch(input logic [31:0] t);
        branch = 1'b1;
        target = t;
        exp_q.delete();
        exp_q.push_back(entry({t[31:2], 2'b00}));
    endtask

    // ---------------- memory responder ----------------
    initial begin
        logic        acc;
        logic [31:0] a;
        mem_if.mem_din_i = 8'h00;
        forever begin
            @(negedge clk);
            acc = mem_if.mem_rd_o & mem_if.mem_grant_i;
            a   = mem_if.mem_a_o;
            @(posedge clk);
            #1;
            mem_if.mem_din_i = acc ? mem_byte(a) : 8'($urandom);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [63:0] e;
        byte_cnt  = 0;
        idle_cnt  = 0;
        n_handoff = 0;
        forever begin
            @(negedge clk);
            if (rst || branch) begin
                byte_cnt = 0;
                idle_cnt = 0;
                continue;
            end
            if (exp_q.size() == 0) begin
                check("sb_queue_empty", 32'(exp_q.size()), 32'd1);
                continue;
            end
            check("sb_pc", if_pc, exp_q[0][63:32]);
            if (byte_cnt == 4) check("sb_rd_after_4", 32'(mem_if.mem_rd_o), 32'd0);
            if (mem_if.mem_rd_o && mem_if.mem_grant_i) begin
                check("sb_addr", mem_if.mem_a_o, exp_q[0][63:32] + 32'(byte_cnt));
                byte_cnt++;
            end
            if (if_valid) begin
                check("sb_valid_bytes", 32'(byte_cnt), 32'd4);
                if (!stall) begin
                    e = exp_q.pop_front();
                    check("sb_handoff_pc", if_pc, e[63:32]);
                    check("sb_handoff_inst", if_inst, e[31:0]);
                    exp_q.push_back(entry(e[63:32] + 32'd4));
                    byte_cnt = 0;
                    idle_cnt = 0;
                    n_handoff++;
                end
            end else begin
                idle_cnt++;
                if (idle_cnt > 200) begin
                    check("sb_watchdog", 32'(idle_cnt), 32'd200);
                    idle_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        stall   = 1'b0;
        branch  = 1'b0;
        target  = 32'h0;
        mem_if.mem_grant_i = 1'b1;
        repeat (2) tick();
        check("rst_rd", 32'(mem_if.mem_rd_o), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, RESET_PC);
        check("rst_inst", if_inst, 32'h0);
        check("rst_addr", mem_if.mem_a_o, RESET_PC);
        check("rst_state", 32'(dbg_state), 32'(IF_ISSUE0));

        // Continuous grant: requests 0..3, valid at cycle 5, next fetch at 6.
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            if (c < 4) begin
                check("t1_rd", 32'(mem_if.mem_rd_o), 32'd1);
                check("t1_addr", mem_if.mem_a_o, 32'(c));
            end
            if (c == 4) check("t1_drain_rd", 32'(mem_if.mem_rd_o), 32'd0);
            check("t1_valid", 32'(if_valid), (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                check("t1_inst", if_inst, 32'h0010_0513);
                check("t1_pc", if_pc, 32'h0);
            end
            if (c == 6) begin
                check("t1_next_addr", mem_if.mem_a_o, 32'd4);
                check("t1_next_rd", 32'(mem_if.mem_rd_o), 32'd1);
            end
            tick();
        end

        // Grant withheld on cycles 1 and 2.
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            mem_if.mem_grant_i = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            if (c >= 1 && c <= 3) check("t2_addr_hold", mem_if.mem_a_o, 32'd1);
            if (c == 4) check("t2_addr2", mem_if.mem_a_o, 32'd2);
            if (c == 5) check("t2_addr3", mem_if.mem_a_o, 32'd3);
            if (c == 6) check("t2_valid_early", 32'(if_valid), 32'd0);
            if (c == 7) begin
                check("t2_valid", 32'(if_valid), 32'd1);
                check("t2_inst", if_inst, 32'h0010_0513);
            end
            tick();
        end

        // Stall for four cycles while VALID.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            stall = (c >= 5 && c <= 8);
            if (c >= 5 && c <= 9) begin
                check("t3_valid", 32'(if_valid), 32'd1);
                check("t3_rd", 32'(mem_if.mem_rd_o), 32'd0);
                check("t3_pc", if_pc, 32'h0);
                check("t3_inst", if_inst, 32'h0010_0513);
            end
            if (c == 10) begin
                check("t3_next_addr", mem_if.mem_a_o, 32'd4);
                check("t3_next_valid", 32'(if_valid), 32'd0);
            end
            tick();
        end

        // Branch during ISSUE2 to an unaligned target.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c == 2) set_branch(32'h0000_0102);
            else branch = 1'b0;
            if (c == 3) begin
                check("t4_addr", mem_if.mem_a_o, 32'h100);
                check("t4_pc", if_pc, 32'h100);
                check("t4_valid", 32'(if_valid), 32'd0);
            end
            if (c == 8) begin
                check("t4_valid_del", 32'(if_valid), 32'd1);
                check("t4_inst", if_inst, exp_word(32'h100));
            end
            tick();
        end

        // Branch coinciding with handoff.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c == 5) set_branch(32'h0000_0040);
            else branch = 1'b0;
            if (c == 6) begin
                check("t5_valid", 32'(if_valid), 32'd0);
                check("t5_pc", if_pc, 32'h40);
                check("t5_addr", mem_if.mem_a_o, 32'h40);
            end
            if (c == 11) check("t5_pc_del", if_pc, 32'h40);
            tick();
        end

        // Wrap at the top of the address space, then async reset mid-ISSUE1.
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) set_branch(32'hFFFF_FFFE);
            else branch = 1'b0;
            if (c >= 1 && c <= 4) check("t6_addr", mem_if.mem_a_o, 32'hFFFF_FFFC + 32'(c - 1));
            if (c == 6) begin
                check("t6_valid", 32'(if_valid), 32'd1);
                check("t6_pc", if_pc, 32'hFFFF_FFFC);
            end
            if (c == 7) begin
                check("t6_wrap_pc", if_pc, 32'h0);
                check("t6_wrap_addr", mem_if.mem_a_o, 32'h0);
            end
            if (c == 8) begin
                check("t6_issue1_addr", mem_if.mem_a_o, 32'h1);
                #1 rst = 1'b1;
                #1;
                check("t6_rst_rd", 32'(mem_if.mem_rd_o), 32'd0);
                check("t6_rst_valid", 32'(if_valid), 32'd0);
                check("t6_rst_pc", if_pc, RESET_PC);
            end else begin
                tick();
            end
        end

        // Randomized grant/stall/branch traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            mem_if.mem_grant_i = ($urandom_range(0, 99) < 70);
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 3) begin
                if ($urandom_range(0, 3) == 0) set_branch(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
                else set_branch($urandom);
            end else begin
                branch = 1'b0;
            end
            tick();
        end
        mem_if.mem_grant_i = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        repeat (30) tick();
        check("rand_handoffs", 32'(n_handoff > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
